// File: rtl/cplx_integrate_dump.sv
// Complex integrate-and-dump accumulator.
// Sums signed I/Q samples over a block of len beats (len==0 means
// 2^LEN_WIDTH beats) or until in_tlast, then presents one wide complex sum.
// AXI-Stream on both sides; a single output register with no skid buffer.
module cplx_integrate_dump #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LEN_WIDTH-1:0]     len,
  input  logic [2*DATA_WIDTH-1:0]  in_tdata,
  input  logic                     in_tvalid,
  input  logic                     in_tlast,
  output logic                     in_tready,
  output logic [2*ACC_WIDTH-1:0]   out_tdata,
  output logic                     out_tvalid,
  output logic                     out_tlast,
  input  logic                     out_tready,
  output logic [LEN_WIDTH-1:0]     out_count
);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  // Sign-extend one input component to accumulator width.
  function automatic logic [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    sext = ACC_WIDTH'($signed(v));
  endfunction

  state_t                 state_r, state_s;
  logic [ACC_WIDTH-1:0]   acc_i_r, acc_q_r, acc_i_s, acc_q_s;
  logic [LEN_WIDTH-1:0]   cnt_r, cnt_s, len_r, len_s;
  logic [ACC_WIDTH-1:0]   samp_i_s, samp_q_s, sum_i_s, sum_q_s;
  logic [LEN_WIDTH-1:0]   fin_cnt_s;
  logic                   accept_s, dump_s;

  // Ready only when the output register is empty or being drained this cycle.
  assign in_tready = !out_tvalid || out_tready;
  assign accept_s  = in_tvalid && in_tready;
  assign samp_i_s  = sext(in_tdata[2*DATA_WIDTH-1:DATA_WIDTH]);
  assign samp_q_s  = sext(in_tdata[DATA_WIDTH-1:0]);

  // Next-state, accumulator update and dump decision.
  always_comb begin
    state_s   = state_r;
    acc_i_s   = acc_i_r;
    acc_q_s   = acc_q_r;
    cnt_s     = cnt_r;
    len_s     = len_r;
    dump_s    = 1'b0;
    sum_i_s   = acc_i_r + samp_i_s;
    sum_q_s   = acc_q_r + samp_q_s;
    fin_cnt_s = cnt_r + LEN_WIDTH'(1);
    case (state_r)
      IDLE: begin
        // First beat of a block loads rather than adds.
        sum_i_s   = samp_i_s;
        sum_q_s   = samp_q_s;
        fin_cnt_s = LEN_WIDTH'(1);
        if (accept_s) begin
          len_s = len;
          if ((len == LEN_WIDTH'(1)) || in_tlast) begin
            dump_s  = 1'b1;
            acc_i_s = {ACC_WIDTH{1'b0}};
            acc_q_s = {ACC_WIDTH{1'b0}};
            cnt_s   = {LEN_WIDTH{1'b0}};
            state_s = IDLE;
          end else begin
            acc_i_s = samp_i_s;
            acc_q_s = samp_q_s;
            cnt_s   = LEN_WIDTH'(1);
            state_s = ACC;
          end
        end else begin
          cnt_s = {LEN_WIDTH{1'b0}};
        end
      end
      ACC: begin
        if (accept_s) begin
          // cnt+1 wraps to zero for len==0, giving a 2^LEN_WIDTH block.
          if ((fin_cnt_s == len_r) || in_tlast) begin
            dump_s  = 1'b1;
            acc_i_s = {ACC_WIDTH{1'b0}};
            acc_q_s = {ACC_WIDTH{1'b0}};
            cnt_s   = {LEN_WIDTH{1'b0}};
            state_s = IDLE;
          end else begin
            acc_i_s = sum_i_s;
            acc_q_s = sum_q_s;
            cnt_s   = fin_cnt_s;
            state_s = ACC;
          end
        end else begin
          state_s = ACC;
        end
      end
      default: begin
        state_s = IDLE;
        acc_i_s = {ACC_WIDTH{1'b0}};
        acc_q_s = {ACC_WIDTH{1'b0}};
        cnt_s   = {LEN_WIDTH{1'b0}};
      end
    endcase
  end

  // Accumulator, counter, latched length and state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      acc_i_r <= {ACC_WIDTH{1'b0}};
      acc_q_r <= {ACC_WIDTH{1'b0}};
      cnt_r   <= {LEN_WIDTH{1'b0}};
      len_r   <= {LEN_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      acc_i_r <= acc_i_s;
      acc_q_r <= acc_q_s;
      cnt_r   <= cnt_s;
      len_r   <= len_s;
    end
  end

  // Output register: load on dump, clear on consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_tdata  <= {(2*ACC_WIDTH){1'b0}};
      out_count  <= {LEN_WIDTH{1'b0}};
    end else if (dump_s) begin
      out_tvalid <= 1'b1;
      out_tlast  <= in_tlast;
      out_tdata  <= {sum_i_s, sum_q_s};
      out_count  <= fin_cnt_s;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end else begin
      out_tvalid <= out_tvalid;
    end
  end

endmodule

// File: tb/tb_cplx_integrate_dump.sv
// Directed self-checking bench for cplx_integrate_dump.
// Main instance uses default parameters; a second LEN_WIDTH=4 instance
// exercises the len==0 (full 2^LEN_WIDTH block) case.
module tb_cplx_integrate_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] len;
  logic [31:0] in_tdata;
  logic        in_tvalid, in_tlast, in_tready;
  logic [79:0] out_tdata;
  logic        out_tvalid, out_tlast, out_tready;
  logic [15:0] out_count;

  logic [3:0]  len2;
  logic [31:0] in2_tdata;
  logic        in2_tvalid, in2_tlast, in2_tready;
  logic [79:0] out2_tdata;
  logic        out2_tvalid, out2_tlast, out2_tready;
  logic [3:0]  out2_count;

  int checks = 0;
  int failures = 0;
  int stall_cnt;
  logic [96:0] mq[$];   // {tdata, tlast, count}

  always #5 clk = ~clk;

  cplx_integrate_dump dut (
    .clk(clk), .reset(reset), .len(len),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
    .out_tready(out_tready), .out_count(out_count)
  );

  cplx_integrate_dump #(.DATA_WIDTH(16), .ACC_WIDTH(40), .LEN_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .len(len2),
    .in_tdata(in2_tdata), .in_tvalid(in2_tvalid), .in_tlast(in2_tlast), .in_tready(in2_tready),
    .out_tdata(out2_tdata), .out_tvalid(out2_tvalid), .out_tlast(out2_tlast),
    .out_tready(out2_tready), .out_count(out2_count)
  );

  // Record every completed output handshake of the main instance.
  always @(negedge clk) begin
    if (!reset && out_tvalid && out_tready) mq.push_back({out_tdata, out_tlast, out_count});
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] mk(input int i, input int q);
    logic signed [39:0] si, sq;
    si = i;
    sq = q;
    return {si, sq};
  endfunction

  function automatic logic [31:0] pk(input int i, input int q);
    logic [15:0] a, b;
    a = i[15:0];
    b = q[15:0];
    return {a, b};
  endfunction

  // Present one beat and wait (bounded) until it is accepted.
  task automatic send(input int i, input int q, input logic last);
    logic rdy;
    bit done = 0;
    in_tvalid = 1'b1;
    in_tdata  = pk(i, q);
    in_tlast  = last;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      rdy = in_tready;
      if (!rdy) stall_cnt++;
      @(posedge clk);
      #1;
      if (rdy) done = 1;
    end
    if (!done) check_eq("send_timeout", 0, 1);
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [79:0] d, input logic l, input logic [15:0] n);
    logic [96:0] e;
    if (mq.size() == 0) begin
      check_eq({tag, "_present"}, 0, 1);
    end else begin
      e = mq.pop_front();
      check_eq({tag, "_data"}, e[96:17], d);
      check_eq({tag, "_last"}, e[16], l);
      check_eq({tag, "_count"}, e[15:0], n);
    end
  endtask

  logic [79:0] hold;
  logic [39:0] tot_i, tot_q;

  initial begin
    reset = 1'b1; len = 16'd0; in_tdata = 32'd0; in_tvalid = 1'b0; in_tlast = 1'b0;
    out_tready = 1'b1;
    len2 = 4'd0; in2_tdata = 32'd0; in2_tvalid = 1'b0; in2_tlast = 1'b0; out2_tready = 1'b0;
    stall_cnt = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", out_tvalid, 0);
    check_eq("rst_data", out_tdata, 0);
    check_eq("rst_count", out_count, 0);
    check_eq("rst_last", out_tlast, 0);
    check_eq("rst_ready", in_tready, 1);
    @(posedge clk); #1;

    // Basic sum, len=4.
    len = 16'd4;
    send(1, -1, 1'b0); send(2, -2, 1'b0); send(3, -3, 1'b0);
    check_eq("basic_no_early", out_tvalid, 0);
    send(4, -4, 1'b0);
    check_eq("basic_latency", out_tvalid, 1);
    repeat (3) @(posedge clk); #1;
    check_eq("basic_n", mq.size(), 1);
    expect_out("basic", mk(10, -10), 1'b0, 16'd4);

    // Early tlast, then a fresh block using the current len.
    len = 16'd8;
    send(100, 50, 1'b0); send(100, 50, 1'b0); send(100, 50, 1'b1);
    len = 16'd2;
    send(1, 1, 1'b0); send(1, 1, 1'b0);
    repeat (3) @(posedge clk); #1;
    check_eq("tlast_n", mq.size(), 2);
    expect_out("tlast", mk(300, 150), 1'b1, 16'd3);
    expect_out("fresh", mk(2, 2), 1'b0, 16'd2);

    // Extremes and full throughput with len=1.
    len = 16'd1;
    stall_cnt = 0;
    for (int k = 0; k < 6; k++) send(-32768, 32767, 1'b0);
    check_eq("thru_stalls", stall_cnt, 0);
    repeat (3) @(posedge clk); #1;
    check_eq("thru_n", mq.size(), 6);
    for (int k = 0; k < 6; k++) expect_out("extreme", mk(-32768, 32767), 1'b0, 16'd1);

    // Backpressure with len=2: stall output 5 cycles after the first result.
    len = 16'd2;
    fork
      begin
        for (int k = 1; k <= 8; k++) send(k, -2 * k, 1'b0);
      end
      begin
        bit seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
          @(posedge clk); #2;
          if (out_tvalid) seen = 1;
        end
        check_eq("bp_first_out", seen, 1);
        out_tready = 1'b0;
        hold = out_tdata;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check_eq("bp_ready_low", in_tready, 0);
          check_eq("bp_data_hold", out_tdata, hold);
        end
        @(posedge clk); #2;
        out_tready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    check_eq("bp_n", mq.size(), 4);
    tot_i = 40'd0; tot_q = 40'd0;
    for (int k = 0; k < mq.size(); k++) begin
      tot_i = tot_i + mq[k][96:57];
      tot_q = tot_q + mq[k][56:17];
    end
    check_eq("bp_total", {tot_i, tot_q}, mk(36, -72));
    expect_out("bp0", mk(3, -6), 1'b0, 16'd2);
    expect_out("bp1", mk(7, -14), 1'b0, 16'd2);
    expect_out("bp2", mk(11, -22), 1'b0, 16'd2);
    expect_out("bp3", mk(15, -30), 1'b0, 16'd2);

    // len=0 on the LEN_WIDTH=4 instance: 16-beat block.
    in2_tvalid = 1'b1;
    in2_tdata  = pk(1, 1);
    repeat (15) @(posedge clk);
    #1;
    check_eq("len0_no_early", out2_tvalid, 0);
    @(posedge clk); #1;
    in2_tvalid = 1'b0;
    check_eq("len0_valid", out2_tvalid, 1);
    check_eq("len0_data", out2_tdata, mk(16, 16));
    check_eq("len0_count", out2_count, 0);
    check_eq("len0_last", out2_tlast, 0);

    // Reset mid-block discards the partial sum.
    len = 16'd4;
    send(7, 7, 1'b0); send(7, 7, 1'b0);
    check_eq("rstmid_none", mq.size(), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rstmid_valid", out_tvalid, 0);
    for (int k = 0; k < 4; k++) send(1, 0, 1'b0);
    repeat (3) @(posedge clk); #1;
    check_eq("rstmid_n", mq.size(), 1);
    expect_out("rstmid", mk(4, 0), 1'b0, 16'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
